// File: rtl/elastic_pipe_stage.sv
// Elastic pipeline register between processor stages: valid/ready handshake,
// two-entry skid buffer, synchronous flush and a saturating stall counter.
module elastic_pipe_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_fire;
    logic             out_fire;
    logic             load_main_in;
    logic             load_main_skid;
    logic             load_skid;

    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;
    assign occupancy = state;

    // Flush overrides everything; the skid only ever refills main so order stays FIFO.
    always_comb begin
        next_state     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            next_state = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        next_state   = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        load_main_in = 1'b1;
                    end else if (in_fire) begin
                        next_state = TWO;
                        load_skid  = 1'b1;
                    end else if (out_fire) begin
                        next_state = EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        next_state     = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: next_state = EMPTY;
            endcase
        end
    end

    // in_ready is registered from next_state, so out_ready never reaches it combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            in_ready <= 1'b0;
            main_q   <= '0;
            skid_q   <= '0;
        end else begin
            state    <= next_state;
            in_ready <= (next_state != TWO);
            if (load_main_in) begin
                main_q <= in_data;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_elastic_pipe_stage.sv
// Directed bench for elastic_pipe_stage: a queue-based reference model acts as
// the scoreboard, pushing accepted entries and popping them as they are delivered.
module tb_elastic_pipe_stage;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] stall_cnt;

    int               vectors;
    int               miscompares;
    logic [31:0]      sb_q[$];
    logic             exp_in_ready;
    logic [31:0]      exp_stall;

    elastic_pipe_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle, compare at the falling edge, then advance the reference model.
    task automatic apply_stimulus(input logic v, input logic [31:0] d,
                                  input logic r, input logic f);
        logic model_in_fire;
        logic model_out_fire;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        @(negedge clk);
        check_output("out_valid", 32'(out_valid), 32'(sb_q.size() != 0));
        check_output("occupancy", 32'(occupancy), 32'(sb_q.size()));
        check_output("in_ready", 32'(in_ready), 32'(exp_in_ready));
        check_output("stall_cnt", 32'(stall_cnt), exp_stall);
        if (sb_q.size() != 0) begin
            check_output("out_data", out_data, sb_q[0]);
        end
        model_in_fire  = v && exp_in_ready;
        model_out_fire = (sb_q.size() != 0) && r;
        if ((sb_q.size() != 0) && !r && (exp_stall != 32'd15)) begin
            exp_stall = exp_stall + 32'd1;
        end
        if (model_out_fire) begin
            void'(sb_q.pop_front());
        end
        if (f) begin
            sb_q.delete();
        end else if (model_in_fire) begin
            sb_q.push_back(d);
        end
        exp_in_ready = f ? 1'b1 : (sb_q.size() != 2);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        exp_in_ready = 1'b0;
        exp_stall    = 32'd0;
        rst_n        = 1'b0;
        flush        = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        out_ready    = 1'b0;

        // Reset and idle
        repeat (3) @(negedge clk);
        check_output("rst_out_valid", 32'(out_valid), 32'd0);
        check_output("rst_in_ready", 32'(in_ready), 32'd0);
        check_output("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        check_output("rst_occupancy", 32'(occupancy), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);

        // Streaming at full rate
        for (int i = 1; i <= 8; i++) begin
            apply_stimulus(1'b1, 32'(i), 1'b1, 1'b0);
        end
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);

        // Back-pressure fills the skid; third push is refused
        apply_stimulus(1'b1, 32'h0000_00A1, 1'b0, 1'b0);
        apply_stimulus(1'b1, 32'h0000_00B2, 1'b0, 1'b0);
        apply_stimulus(1'b1, 32'h0000_0DEA, 1'b0, 1'b0);
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);

        // Flush while full, with a concurrent push of C
        apply_stimulus(1'b1, 32'h0000_0A02, 1'b0, 1'b0);
        apply_stimulus(1'b1, 32'h0000_0B02, 1'b0, 1'b0);
        apply_stimulus(1'b1, 32'h0000_0C0C, 1'b0, 1'b1);
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);

        // Flush while one entry is delivered and another is offered
        apply_stimulus(1'b1, 32'h0000_00D4, 1'b0, 1'b0);
        apply_stimulus(1'b1, 32'h0000_00E5, 1'b1, 1'b1);
        apply_stimulus(1'b1, 32'h0000_00F6, 1'b1, 1'b0);
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);

        // Stall counter saturation, unaffected by flush
        apply_stimulus(1'b1, 32'h0000_0077, 1'b0, 1'b0);
        repeat (20) apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
        check_output("stall_saturated", 32'(stall_cnt), 32'd15);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
        check_output("stall_after_flush", 32'(stall_cnt), 32'd15);

        // Asynchronous reset while full
        apply_stimulus(1'b1, 32'h0000_0111, 1'b0, 1'b0);
        apply_stimulus(1'b1, 32'h0000_0222, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async_out_valid", 32'(out_valid), 32'd0);
        check_output("async_occupancy", 32'(occupancy), 32'd0);
        check_output("async_in_ready", 32'(in_ready), 32'd0);
        check_output("async_stall_cnt", 32'(stall_cnt), 32'd0);
        sb_q.delete();
        exp_stall    = 32'd0;
        exp_in_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_in_ready = 1'b1;
        apply_stimulus(1'b1, 32'h0000_0333, 1'b1, 1'b0);
        apply_stimulus(1'b1, 32'h0000_0444, 1'b1, 1'b0);
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
        check_output("drained", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
